// File: rtl/prco_mem_ctrl.sv
// Initiator side of the local-memory strobe protocol: one-entry fetch and data slots, data-first issue,
// completion/timeout tracking. Define PRCO_MEM_CTRL_STATS_EN to add saturating event counters.
module prco_mem_ctrl #(
    parameter int P_ADDR_W  = 16,
    parameter int P_DATA_W  = 16,
    parameter int P_TIMEOUT = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_fetch_req,
    input  logic [P_ADDR_W-1:0] i_pc,
    input  logic                i_ld_req,
    input  logic                i_st_req,
    input  logic [P_ADDR_W-1:0] i_addr,
    input  logic [P_DATA_W-1:0] i_wdata,
    input  logic                i_err_clr,
    output logic                q_fetch_rdy,
    output logic                q_data_rdy,
    output logic [P_DATA_W-1:0] q_instr,
    output logic                q_instr_valid,
    output logic [P_DATA_W-1:0] q_rdata,
    output logic                q_rdata_valid,
    output logic                q_st_done,
    output logic                q_err,
    output logic [1:0]          q_err_code,
    output logic                q_ce_fetch,
    output logic                q_ce_alu,
    output logic                q_mem_we,
    output logic [P_ADDR_W-1:0] q_mem_addr,
    output logic [P_DATA_W-1:0] q_mem_dina,
`ifdef PRCO_MEM_CTRL_STATS_EN
    output logic [15:0]         q_n_fetch,
    output logic [15:0]         q_n_load,
    output logic [15:0]         q_n_store,
    output logic [15:0]         q_n_timeout,
`endif
    input  logic                i_ce_dec,
    input  logic                i_ce_reg,
    input  logic [P_DATA_W-1:0] i_mem_douta
);

    localparam int            TW    = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(P_TIMEOUT - 1);

    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_STROBE   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_F = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tcnt, tcnt_next;

    logic [P_ADDR_W-1:0] fetch_pc, data_addr;
    logic [P_DATA_W-1:0] data_wdata;
    logic                data_we;

    logic                issue_fetch, issue_data;
    logic                ce_fetch_next, ce_alu_next, mem_we_next;
    logic [P_ADDR_W-1:0] mem_addr_next;
    logic [P_DATA_W-1:0] mem_dina_next, instr_next, rdata_next;
    logic                instr_valid_next, rdata_valid_next, st_done_next;
    logic                fsm_err;
    logic [1:0]          fsm_code;
    logic                data_req, overflow;

    assign data_req = i_ld_req | i_st_req;
    assign overflow = (i_fetch_req & ~q_fetch_rdy) | (data_req & ~q_data_rdy);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
            tcnt  <= tcnt_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next       = state;
        tcnt_next        = tcnt;
        issue_fetch      = 1'b0;
        issue_data       = 1'b0;
        ce_fetch_next    = 1'b0;
        ce_alu_next      = 1'b0;
        mem_we_next      = q_mem_we;
        mem_addr_next    = q_mem_addr;
        mem_dina_next    = q_mem_dina;
        instr_next       = q_instr;
        instr_valid_next = 1'b0;
        rdata_next       = q_rdata;
        rdata_valid_next = 1'b0;
        st_done_next     = 1'b0;
        fsm_err          = 1'b0;
        fsm_code         = 2'b00;

        case (state)
            IDLE: begin
                if (!q_data_rdy) begin
                    issue_data    = 1'b1;
                    ce_alu_next   = 1'b1;
                    mem_addr_next = data_addr;
                    mem_we_next   = data_we;
                    mem_dina_next = data_wdata;
                    tcnt_next     = '0;
                    state_next    = WAIT_D;
                end else if (!q_fetch_rdy) begin
                    issue_fetch   = 1'b1;
                    ce_fetch_next = 1'b1;
                    mem_addr_next = fetch_pc;
                    mem_we_next   = 1'b0;
                    tcnt_next     = '0;
                    state_next    = WAIT_F;
                end
            end
            WAIT_F: begin
                if (i_ce_dec) begin
                    instr_next       = i_mem_douta;
                    instr_valid_next = 1'b1;
                    state_next       = IDLE;
                end else if (i_ce_reg) begin
                    fsm_err    = 1'b1;
                    fsm_code   = ERR_STROBE;
                    state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    fsm_err    = 1'b1;
                    fsm_code   = ERR_TIMEOUT;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            WAIT_D: begin
                if (i_ce_reg) begin
                    // q_mem_we still holds the type of the access in flight
                    if (q_mem_we) begin
                        st_done_next = 1'b1;
                    end else begin
                        rdata_next       = i_mem_douta;
                        rdata_valid_next = 1'b1;
                    end
                    state_next = IDLE;
                end else if (i_ce_dec) begin
                    fsm_err    = 1'b1;
                    fsm_code   = ERR_STROBE;
                    state_next = IDLE;
                end else if (tcnt == TLAST) begin
                    fsm_err    = 1'b1;
                    fsm_code   = ERR_TIMEOUT;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_ce_fetch    <= 1'b0;
            q_ce_alu      <= 1'b0;
            q_mem_we      <= 1'b0;
            q_mem_addr    <= '0;
            q_mem_dina    <= '0;
            q_instr       <= '0;
            q_instr_valid <= 1'b0;
            q_rdata       <= '0;
            q_rdata_valid <= 1'b0;
            q_st_done     <= 1'b0;
        end else begin
            q_ce_fetch    <= ce_fetch_next;
            q_ce_alu      <= ce_alu_next;
            q_mem_we      <= mem_we_next;
            q_mem_addr    <= mem_addr_next;
            q_mem_dina    <= mem_dina_next;
            q_instr       <= instr_next;
            q_instr_valid <= instr_valid_next;
            q_rdata       <= rdata_next;
            q_rdata_valid <= rdata_valid_next;
            q_st_done     <= st_done_next;
        end
    end

    // A slot can only be issued while full, so issue and capture never collide.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_fetch_rdy <= 1'b1;
            fetch_pc    <= '0;
            q_data_rdy  <= 1'b1;
            data_addr   <= '0;
            data_wdata  <= '0;
            data_we     <= 1'b0;
        end else begin
            if (issue_fetch) begin
                q_fetch_rdy <= 1'b1;
            end else if (i_fetch_req && q_fetch_rdy) begin
                q_fetch_rdy <= 1'b0;
                fetch_pc    <= i_pc;
            end
            if (issue_data) begin
                q_data_rdy <= 1'b1;
            end else if (data_req && q_data_rdy) begin
                q_data_rdy <= 1'b0;
                data_addr  <= i_addr;
                data_wdata <= i_wdata;
                data_we    <= i_st_req;
            end
        end
    end

    // First error sticks; a new error in the clearing cycle is recorded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_err      <= 1'b0;
            q_err_code <= 2'b00;
        end else if (i_err_clr || !q_err) begin
            if (fsm_err) begin
                q_err      <= 1'b1;
                q_err_code <= fsm_code;
            end else if (overflow) begin
                q_err      <= 1'b1;
                q_err_code <= ERR_OVERFLOW;
            end else if (i_err_clr) begin
                q_err      <= 1'b0;
                q_err_code <= 2'b00;
            end
        end
    end

`ifdef PRCO_MEM_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_n_fetch   <= '0;
            q_n_load    <= '0;
            q_n_store   <= '0;
            q_n_timeout <= '0;
        end else begin
            if (instr_valid_next) q_n_fetch <= sat_inc(q_n_fetch);
            if (rdata_valid_next) q_n_load  <= sat_inc(q_n_load);
            if (st_done_next)     q_n_store <= sat_inc(q_n_store);
            if (fsm_err && (fsm_code == ERR_TIMEOUT)) q_n_timeout <= sat_inc(q_n_timeout);
        end
    end
`endif

endmodule

// File: tb/tb_prco_mem_ctrl.sv
// Self-checking bench for prco_mem_ctrl: directed protocol scenarios plus randomized fetch/load/store
// traffic checked against a plain memory-array reference model.
module tb_prco_mem_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req, ld_req, st_req, err_clr;
    logic [AW-1:0] pc, addr;
    logic [DW-1:0] wdata;
    logic          fetch_rdy, data_rdy, instr_valid, rdata_valid, st_done, err;
    logic [DW-1:0] instr, rdata;
    logic [1:0]    err_code;
    logic          ce_fetch, ce_alu, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dina;
    logic          ce_dec, ce_reg;
    logic [DW-1:0] mem_douta;

    int n_vec = 0;
    int n_err = 0;

    // Memory model state: device contents, responder behaviour, last strobe seen.
    logic [DW-1:0] dev_mem [256];
    logic [DW-1:0] ref_mem [256];
    int            resp_mode  = 0;   // 0 normal, 1 silent, 2 wrong strobe
    int            resp_delay = 0;
    logic          last_fetch, last_we, resp_dec;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_din;

    always #5 clk = ~clk;

    prco_mem_ctrl #(.P_ADDR_W(AW), .P_DATA_W(DW), .P_TIMEOUT(TMO)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_fetch_req  (fetch_req),
        .i_pc         (pc),
        .i_ld_req     (ld_req),
        .i_st_req     (st_req),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_err_clr    (err_clr),
        .q_fetch_rdy  (fetch_rdy),
        .q_data_rdy   (data_rdy),
        .q_instr      (instr),
        .q_instr_valid(instr_valid),
        .q_rdata      (rdata),
        .q_rdata_valid(rdata_valid),
        .q_st_done    (st_done),
        .q_err        (err),
        .q_err_code   (err_code),
        .q_ce_fetch   (ce_fetch),
        .q_ce_alu     (ce_alu),
        .q_mem_we     (mem_we),
        .q_mem_addr   (mem_addr),
        .q_mem_dina   (mem_dina),
        .i_ce_dec     (ce_dec),
        .i_ce_reg     (ce_reg),
        .i_mem_douta  (mem_douta)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic f, input logic ld, input logic st,
                             input logic [15:0] p, input logic [15:0] a, input logic [15:0] d);
        fetch_req = f; ld_req = ld; st_req = st; pc = p; addr = a; wdata = d;
        @(negedge clk);
        fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_event(input int which, input int budget, output int n, output logic seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       seen = instr_valid;
                1:       seen = rdata_valid;
                default: seen = st_done;
            endcase
        end
    endtask

    // Memory responder: sees a strobe just after the edge that raised it, answers one cycle later.
    initial begin
        ce_dec = 1'b0; ce_reg = 1'b0; mem_douta = '0;
        forever begin
            @(posedge clk); #1;
            if (ce_fetch || ce_alu) begin
                last_fetch = ce_fetch;
                last_addr  = mem_addr;
                last_we    = mem_we;
                last_din   = mem_dina;
                if (ce_alu && mem_we) dev_mem[mem_addr[7:0]] = mem_dina;
                if (resp_mode != 1) begin
                    repeat (resp_delay) @(posedge clk);
                    @(posedge clk); #1;
                    resp_dec  = last_fetch ^ (resp_mode == 2);
                    ce_dec    = resp_dec;
                    ce_reg    = !resp_dec;
                    mem_douta = dev_mem[last_addr[7:0]];
                    @(posedge clk); #1;
                    ce_dec = 1'b0;
                    ce_reg = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v, a, d;
        logic        seen, both_high;
        logic [15:0] got_r, got_i;
        int          n, kind, r_cnt, i_cnt;
        int          evq[$];

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        dev_mem[3] = 16'h6820;
        ref_mem[3] = 16'h6820;

        rst = 1'b1;
        fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; err_clr = 1'b0;
        pc = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_fetch_rdy", fetch_rdy, 1);
        check("rst_data_rdy", data_rdy, 1);
        check("rst_ce", {ce_fetch, ce_alu, mem_we}, 0);
        check("rst_valids", {instr_valid, rdata_valid, st_done}, 0);
        check("rst_err", {err, err_code}, 0);
        check("rst_data", {instr, rdata}, 0);
        check("rst_mem_bus", {mem_addr, mem_dina}, 0);

        // Fetch 0x0003, step by step
        pulse_req(1, 0, 0, 16'h0003, 0, 0);
        check("f_slot_full", fetch_rdy, 0);
        @(negedge clk);
        check("f_ce_fetch", ce_fetch, 1);
        check("f_ce_alu_low", ce_alu, 0);
        check("f_addr", mem_addr, 16'h0003);
        check("f_we", mem_we, 0);
        @(negedge clk);
        check("f_ce_drop", {ce_fetch, instr_valid}, 0);
        @(negedge clk);
        check("f_valid", instr_valid, 1);
        check("f_instr", instr, 16'h6820);
        @(negedge clk);
        check("f_valid_pulse", instr_valid, 0);
        check("f_instr_hold", instr, 16'h6820);

        // Store 0x00CA to 0x00AA, then load it back
        pulse_req(0, 0, 1, 0, 16'h00AA, 16'h00CA);
        @(negedge clk);
        check("st_ce_alu", {ce_alu, ce_fetch}, 2'b10);
        check("st_we", mem_we, 1);
        check("st_addr", mem_addr, 16'h00AA);
        check("st_dina", mem_dina, 16'h00CA);
        wait_event(2, 20, n, seen);
        check("st_done_seen", seen, 1);
        check("st_done_lat", n, 2);
        ref_mem[8'hAA] = 16'h00CA;
        @(negedge clk);
        pulse_req(0, 1, 0, 0, 16'h00AA, 16'h1111);
        wait_event(1, 20, n, seen);
        check("ld_seen", seen, 1);
        check("ld_lat", n, 3);
        check("ld_rdata", rdata, ref_mem[8'hAA]);
        check("ld_we_hold", mem_we, 0);

        // Load and store together: the store wins
        @(negedge clk);
        pulse_req(0, 1, 1, 0, 16'h00BB, 16'h1357);
        wait_event(2, 20, n, seen);
        check("ldst_done", seen, 1);
        check("ldst_we", last_we, 1);
        check("ldst_din", last_din, 16'h1357);
        ref_mem[8'hBB] = 16'h1357;
        @(negedge clk);
        pulse_req(0, 1, 0, 0, 16'h00BB, 0);
        wait_event(1, 20, n, seen);
        check("ldst_readback", rdata, ref_mem[8'hBB]);

        // Fetch and load together: data first, then fetch, each valid once
        @(negedge clk);
        pulse_req(1, 1, 0, 16'h0010, 16'h0020, 0);
        both_high = 1'b0;
        got_r = '0; got_i = '0;
        for (int c = 0; c < 20; c++) begin
            if (ce_alu) evq.push_back(1);
            if (ce_fetch) evq.push_back(3);
            if (rdata_valid) begin evq.push_back(2); got_r = rdata; end
            if (instr_valid) begin evq.push_back(4); got_i = instr; end
            if (ce_alu && ce_fetch) both_high = 1'b1;
            @(negedge clk);
        end
        check("arb_events", evq.size(), 4);
        if (evq.size() == 4) begin
            check("arb_order", {evq[0][3:0], evq[1][3:0], evq[2][3:0], evq[3][3:0]}, 16'h1234);
        end
        check("arb_exclusive", both_high, 0);
        check("arb_rdata", got_r, ref_mem[8'h20]);
        check("arb_instr", got_i, ref_mem[8'h10]);

        // Silent memory: timeout
        resp_mode = 1;
        pulse_req(1, 0, 0, 16'h0070, 0, 0);
        @(negedge clk);
        check("to_strobe", ce_fetch, 1);
        n = 0; i_cnt = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
            if (instr_valid) i_cnt++;
        end
        check("to_latency", (n >= TMO && n <= TMO + 1), 1);
        check("to_code", {err, err_code}, 3'b101);
        check("to_no_valid", i_cnt, 0);
        resp_mode = 0;
        pulse_clr();
        check("to_clear", err, 0);
        pulse_req(1, 0, 0, 16'h0071, 0, 0);
        wait_event(0, 20, n, seen);
        check("to_recover_lat", n, 3);
        check("to_recover_instr", instr, ref_mem[8'h71]);

        // Second load while the data slot is full
        @(negedge clk);
        resp_delay = 4;
        pulse_req(1, 0, 0, 16'h0030, 0, 0);
        pulse_req(0, 1, 0, 0, 16'h0040, 0);
        check("ovf_slot_full", data_rdy, 0);
        pulse_req(0, 1, 0, 0, 16'h0050, 0);
        check("ovf_code", {err, err_code}, 3'b110);
        r_cnt = 0; i_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (rdata_valid) begin r_cnt++; got_r = rdata; end
            if (instr_valid) i_cnt++;
            @(negedge clk);
        end
        check("ovf_one_load", r_cnt, 1);
        check("ovf_one_fetch", i_cnt, 1);
        check("ovf_kept_load", got_r, ref_mem[8'h40]);
        check("ovf_last_addr", last_addr, 16'h0040);
        pulse_clr();
        check("ovf_clear", err, 0);

        // Wrong completion strobe during WAIT_F
        resp_delay = 0;
        resp_mode = 2;
        pulse_req(1, 0, 0, 16'h0060, 0, 0);
        i_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (instr_valid) i_cnt++;
            @(negedge clk);
        end
        check("strb_code", {err, err_code}, 3'b111);
        check("strb_no_valid", i_cnt, 0);
        resp_mode = 0;
        pulse_clr();
        check("strb_clear", err, 0);

        // Reset during WAIT_D with a late response
        resp_delay = 3;
        pulse_req(0, 1, 0, 0, 16'h0080, 0);
        @(negedge clk);
        check("rstmid_issue", ce_alu, 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_ce", {ce_alu, ce_fetch, mem_we}, 0);
        check("rstmid_bus", {mem_addr, rdata}, 0);
        check("rstmid_rdy", {fetch_rdy, data_rdy}, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        r_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdata_valid) r_cnt++;
        end
        check("rstmid_no_valid", r_cnt, 0);
        check("rstmid_no_err", err, 0);

        // Randomized traffic against the memory-array reference
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 2));
            a = 16'($urandom);
            d = 16'($urandom);
            resp_delay = int'($urandom_range(0, 5));
            case (kind)
                0: begin
                    pulse_req(1, 0, 0, a, 0, 0);
                    wait_event(0, 30, n, seen);
                    check("rnd_fetch_seen", seen, 1);
                    check("rnd_fetch_data", instr, ref_mem[a[7:0]]);
                    check("rnd_fetch_kind", last_fetch, 1);
                end
                1: begin
                    pulse_req(0, 1, 0, 0, a, d);
                    wait_event(1, 30, n, seen);
                    check("rnd_load_seen", seen, 1);
                    check("rnd_load_data", rdata, ref_mem[a[7:0]]);
                    check("rnd_load_we", last_we, 0);
                end
                default: begin
                    pulse_req(0, 0, 1, 0, a, d);
                    wait_event(2, 30, n, seen);
                    check("rnd_store_seen", seen, 1);
                    check("rnd_store_din", last_din, d);
                    check("rnd_store_we", last_we, 1);
                    ref_mem[a[7:0]] = d;
                end
            endcase
            check("rnd_latency", n, 3 + resp_delay);
            check("rnd_addr", last_addr, (kind == 0) ? a : a);
            @(negedge clk);
        end
        check("rnd_no_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prco_mem_ctrl.md
Name: prco_mem_ctrl

Overview:
- Initiator side of the local-memory strobe protocol. Sequences instruction fetches and ALU load/store accesses into the single-port local memory.
- Arbitrates between the two request sources, holds each request in a 1-entry slot, and waits for the memory's completion strobe.
- Returns instruction/read data to the core. Flags protocol errors and timeouts.

Parameters:
- P_ADDR_W, 16, memory address width.
- P_DATA_W, 16, memory data width.
- P_TIMEOUT, 15, max cycles in a WAIT state before timeout error (>=2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_fetch_req  in  1  fetch request pulse (sampled only when q_fetch_rdy=1).
- i_pc  in  P_ADDR_W  fetch address.
- i_ld_req  in  1  load request pulse.
- i_st_req  in  1  store request pulse.
- i_addr  in  P_ADDR_W  load/store address.
- i_wdata  in  P_DATA_W  store data.
- i_err_clr  in  1  clears sticky error.
- q_fetch_rdy  out  1  fetch slot empty.
- q_data_rdy  out  1  data slot empty.
- q_instr  out  P_DATA_W  last fetched instruction.
- q_instr_valid  out  1  one-cycle pulse, q_instr updated.
- q_rdata  out  P_DATA_W  last load data.
- q_rdata_valid  out  1  one-cycle pulse, q_rdata updated.
- q_st_done  out  1  one-cycle pulse, store completed.
- q_err  out  1  sticky error flag.
- q_err_code  out  2  01 timeout, 10 request overflow, 11 unexpected strobe.
- q_ce_fetch  out  1  memory fetch strobe.
- q_ce_alu  out  1  memory data-access strobe.
- q_mem_we  out  1  memory write enable (valid with q_ce_alu).
- q_mem_addr  out  P_ADDR_W  memory address.
- q_mem_dina  out  P_DATA_W  memory write data.
- i_ce_dec  in  1  memory fetch-complete strobe; i_mem_douta valid.
- i_ce_reg  in  1  memory data-complete strobe.
- i_mem_douta  in  P_DATA_W  memory read data.

Behaviour:
- Reset: all outputs 0; q_fetch_rdy = q_data_rdy = 1; slots empty; FSM = IDLE; timeout counter 0.
- Slot capture:
  - i_fetch_req with fetch slot empty latches i_pc.
  - i_ld_req or i_st_req with data slot empty latches i_addr, i_wdata and we (=i_st_req).
  - ld and st together: store wins.
  - Any request while its slot is full is dropped and sets q_err with code 10.
- FSM states: IDLE, WAIT_F, WAIT_D. All outputs registered.
- IDLE:
  - Data slot full: pulse q_ce_alu for one cycle, drive q_mem_addr/q_mem_we/q_mem_dina from the slot, clear the data slot, go to WAIT_D.
  - Else fetch slot full: pulse q_ce_fetch, drive q_mem_addr=pc, q_mem_we=0, clear the fetch slot, go to WAIT_F.
  - Data has priority over fetch. q_ce_fetch and q_ce_alu are never high together.
  - Response strobes arriving in IDLE are ignored.
- WAIT_F:
  - i_ce_dec: q_instr<=i_mem_douta, pulse q_instr_valid, go to IDLE.
  - i_ce_reg: set error 11, go to IDLE.
- WAIT_D:
  - i_ce_reg: if load, q_rdata<=i_mem_douta and pulse q_rdata_valid; if store, pulse q_st_done. Go to IDLE.
  - i_ce_dec: set error 11, go to IDLE.
- Timeout:
  - Counter clears on entry to a WAIT state and increments each WAIT cycle.
  - At P_TIMEOUT with no strobe: error 01, go to IDLE, and drop the request (no valid pulse).
- Latency: request sampled at edge E0 -> strobe high E1..E2 -> memory response E2..E3 -> valid pulse E3..E4. Back-to-back issue gap: 1 IDLE cycle minimum.
- q_mem_addr/q_mem_dina/q_mem_we hold their values until the next issue.
- Errors: q_err/q_err_code keep the first error until i_err_clr. An error in the same cycle as i_err_clr is recorded (set wins).
- Reset mid-operation aborts the transaction. No valid pulses are emitted for it.

Optional Feature:
- PRCO_MEM_CTRL_STATS_EN: adds 16-bit outputs q_n_fetch, q_n_load, q_n_store, q_n_timeout.
  - Each counter increments on its completion/timeout event, saturates at 16'hFFFF, and clears on reset.
- Without the macro these ports and counters do not exist.

Test Plan:
- Fetch i_pc=0x0003, memory model returns 16'h6820 -> q_ce_fetch pulse with q_mem_addr=0x0003; q_instr=16'h6820, q_instr_valid pulse 3 edges after the request.
- Store 0x00CA to 0x00AA, then load 0x00AA -> q_ce_alu+q_mem_we=1, q_mem_dina=0x00CA, q_st_done pulse; then q_rdata=0x00CA, q_rdata_valid pulse.
- Fetch and load requested in the same cycle -> q_ce_alu issued first, q_ce_fetch after the data completion; both valid pulses delivered once, in that order.
- Memory never responds to a fetch -> q_err=1, q_err_code=01 after P_TIMEOUT cycles; FSM back in IDLE; i_err_clr clears it.
- Second load while the data slot is full -> request dropped, q_err_code=10. Separately, i_ce_reg during WAIT_F -> q_err_code=11.
- Assert i_reset during WAIT_D -> all outputs 0 immediately; a late i_ce_reg produces no q_rdata_valid.
